iodec_seq: RTL and testbench

IODEC_SEQ -- requirements
Module: iodec_seq

---
 rtl/iodec_pkg.sv | 8 +
 rtl/iodec_onehot.sv | 12 +
 rtl/iodec_seq.sv | 82 ++++++++
 tb/tb_iodec_seq.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/iodec_pkg.sv
// iodec_pkg: shared field widths, page default and FSM state encoding for the I/O decoder
package iodec_pkg;
  localparam int PW = 8;
  localparam int IW = 7;
  localparam int WW = 4;
  localparam logic [PW-1:0] PAGE_DEF = 8'h00;
  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, ACK = 2'd2} state_e;
endpackage

// File: rtl/iodec_onehot.sv
// iodec_onehot: binary register index plus enable to N-bit one-hot vector
module iodec_onehot import iodec_pkg::*; #(
  parameter int N = 32
) (
  input  logic [IW-1:0] idx,
  input  logic          en,
  output logic [N-1:0]  oh
);
  for (genvar i = 0; i < N; i++) begin : g_oh
    assign oh[i] = en && idx == IW'(i);
  end
endmodule

// File: rtl/iodec_seq.sv
// iodec_seq: paged register decoder with programmable wait states and registered strobes
module iodec_seq import iodec_pkg::*; #(
  parameter int              NREG   = 32,
  parameter logic [PW-1:0]   PAGE   = PAGE_DEF,
  parameter int              WAITS  = 1,
  parameter logic [NREG-1:0] RDMASK = '1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [15:0]     a,
  input  logic            intdev,
  input  logic            start,
  input  logic            reads,
  input  logic            errclr,
  output logic [NREG-1:0] wstb,
  output logic [NREG-1:0] rsel,
  output logic            floaten,
  output logic            ack,
  output logic            err
);
  if (NREG < 2 || NREG > 128) begin : g_bad_nreg
    $error("iodec_seq: NREG must be 2..128");
  end
  if (WAITS < 0 || WAITS > 15) begin : g_bad_waits
    $error("iodec_seq: WAITS must be 0..15");
  end
  localparam logic [IW:0]    NR  = (IW + 1)'(NREG);
  localparam logic [WW-1:0]  WLD = WAITS == 0 ? '0 : WW'(WAITS - 1);
  localparam logic [127:0]   RDM = 128'(RDMASK);
  state_e          st, nxt;
  logic [WW-1:0]   cnt, cnt_n;
  logic [IW-1:0]   idx, idx_n;
  logic            rd, rd_n, map, map_n;
  logic            hit, accept, busy_n, wen, ren, float_n, set;
  logic [NREG-1:0] wstb_n, rsel_n;
  logic            unused_a0;
  assign unused_a0 = a[0];
  always_comb begin
    hit     = start && intdev && a[15:8] == PAGE;
    accept  = st == IDLE && hit;
    idx_n   = accept ? a[7:1] : idx;
    rd_n    = accept ? reads : rd;
    map_n   = accept ? {1'b0, a[7:1]} < NR : map;
    cnt_n   = accept ? WLD : st == WAIT ? cnt - 1'b1 : cnt;
    nxt     = st == ACK ? IDLE :
              st == WAIT ? (cnt == '0 ? ACK : WAIT) :
              accept ? (WAITS == 0 ? ACK : WAIT) : IDLE;
    busy_n  = nxt != IDLE;
    // outputs are computed from next-state values so they can be registered yet line up with the state
    wen     = nxt == ACK && !rd_n && map_n;
    ren     = busy_n && rd_n && map_n && RDM[idx_n];
    float_n = busy_n && rd_n && !(map_n && RDM[idx_n]);
    set     = nxt == ACK && !map_n;
  end
  iodec_onehot #(.N(NREG)) u_wr (.idx(idx_n), .en(wen), .oh(wstb_n));
  iodec_onehot #(.N(NREG)) u_rd (.idx(idx_n), .en(ren), .oh(rsel_n));
  always_ff @(posedge clk) begin
    if (reset) begin
      st      <= IDLE;
      cnt     <= '0;
      idx     <= '0;
      rd      <= 1'b0;
      map     <= 1'b0;
      wstb    <= '0;
      rsel    <= '0;
      floaten <= 1'b0;
      ack     <= 1'b0;
      err     <= 1'b0;
    end else begin
      st      <= nxt;
      cnt     <= cnt_n;
      idx     <= idx_n;
      rd      <= rd_n;
      map     <= map_n;
      wstb    <= wstb_n;
      rsel    <= rsel_n;
      floaten <= float_n;
      ack     <= nxt == ACK;
      err     <= set || (err && !errclr);
    end
  end
endmodule

// File: tb/tb_iodec_seq.sv
// tb_iodec_seq: directed vectors against three decoder configurations (WAITS 0, 1, 3)
module tb_iodec_seq;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] a = '0;
  logic        intdev = 1'b0, start = 1'b0, reads = 1'b0, errclr = 1'b0;
  logic [31:0] wstb0, rsel0, wstb1, rsel1, wstb3, rsel3;
  logic        fl0, ack0, err0, fl1, ack1, err1, fl3, ack3, err3;
  int          nvec = 0, nerr = 0;
  logic [3:0]  acc;
  always #5 clk = ~clk;
  iodec_seq #(.WAITS(0)) u0 (.clk(clk), .reset(reset), .a(a), .intdev(intdev), .start(start),
    .reads(reads), .errclr(errclr), .wstb(wstb0), .rsel(rsel0), .floaten(fl0), .ack(ack0), .err(err0));
  iodec_seq #(.WAITS(1), .RDMASK(32'hFFFF_FFDF)) u1 (.clk(clk), .reset(reset), .a(a), .intdev(intdev),
    .start(start), .reads(reads), .errclr(errclr), .wstb(wstb1), .rsel(rsel1), .floaten(fl1), .ack(ack1), .err(err1));
  iodec_seq #(.WAITS(3)) u3 (.clk(clk), .reset(reset), .a(a), .intdev(intdev), .start(start),
    .reads(reads), .errclr(errclr), .wstb(wstb3), .rsel(rsel3), .floaten(fl3), .ack(ack3), .err(err3));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic go(input logic [15:0] addr, input logic rdc);
    a = addr; reads = rdc; intdev = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask
  task automatic clear_err();
    errclr = 1'b1;
    tick();
    errclr = 1'b0;
  endtask
  initial begin
    tick(); tick();
    reset = 1'b0;
    chk("rst_ack", {31'b0, ack1}, 0);
    chk("rst_wstb", wstb1, 0);
    chk("rst_rsel", rsel1, 0);
    chk("rst_float", {31'b0, fl1}, 0);
    chk("rst_err", {31'b0, err1}, 0);
    // write idx 2, WAITS=1: ack two edges after start
    go(16'h0004, 1'b0);
    chk("wr_u0_wstb", wstb0, 32'h4);
    chk("wr_c1_ack", {31'b0, ack1}, 0);
    chk("wr_c1_wstb", wstb1, 0);
    tick();
    chk("wr_c2_ack", {31'b0, ack1}, 1);
    chk("wr_c2_wstb", wstb1, 32'h4);
    chk("wr_c2_err", {31'b0, err1}, 0);
    tick();
    chk("wr_c3_ack", {31'b0, ack1}, 0);
    chk("wr_c3_wstb", wstb1, 0);
    idle(3);
    // read idx 15
    go(16'h001E, 1'b1);
    chk("rd_u0_ack", {31'b0, ack0}, 1);
    chk("rd_u0_rsel", rsel0, 32'h8000);
    chk("rd_u0_float", {31'b0, fl0}, 0);
    chk("rd_u1_rsel_early", rsel1, 32'h8000);
    chk("rd_u1_ack_early", {31'b0, ack1}, 0);
    tick();
    chk("rd_u1_ack", {31'b0, ack1}, 1);
    chk("rd_u1_rsel", rsel1, 32'h8000);
    chk("rd_u1_wstb", wstb1, 0);
    tick();
    chk("rd_u1_rsel_end", rsel1, 0);
    idle(3);
    // idx 5 is masked unreadable in u1
    go(16'h000A, 1'b1);
    chk("nr_c1_float", {31'b0, fl1}, 1);
    chk("nr_c1_rsel", rsel1, 0);
    tick();
    chk("nr_c2_ack", {31'b0, ack1}, 1);
    chk("nr_c2_float", {31'b0, fl1}, 1);
    chk("nr_c2_err", {31'b0, err1}, 0);
    tick();
    chk("nr_c3_float", {31'b0, fl1}, 0);
    idle(3);
    // unmapped read idx 127
    go(16'h00FE, 1'b1);
    chk("um_c1_float", {31'b0, fl1}, 1);
    chk("um_c1_rsel", rsel1, 0);
    chk("um_c1_err", {31'b0, err1}, 0);
    tick();
    chk("um_c2_ack", {31'b0, ack1}, 1);
    chk("um_c2_float", {31'b0, fl1}, 1);
    chk("um_c2_err", {31'b0, err1}, 1);
    tick();
    chk("um_c3_float", {31'b0, fl1}, 0);
    chk("um_c3_err", {31'b0, err1}, 1);
    idle(3);
    clear_err();
    chk("um_clr", {31'b0, err1}, 0);
    // unmapped write idx 32 with errclr coincident: set wins, no strobe
    errclr = 1'b1;
    go(16'h0040, 1'b0);
    errclr = 1'b0;
    chk("uw_ack", {31'b0, ack0}, 1);
    chk("uw_wstb", wstb0, 0);
    chk("uw_setwins", {31'b0, err0}, 1);
    idle(4);
    clear_err();
    chk("uw_clr", {31'b0, err0}, 0);
    // page miss and intdev low
    acc = '0;
    go(16'h0204, 1'b0);
    for (int i = 0; i < 5; i++) begin
      acc |= {ack1 | ack0 | ack3, |wstb1, |rsel1, fl1};
      tick();
    end
    chk("pmiss", {28'b0, acc}, 0);
    acc = '0;
    a = 16'h0004; reads = 1'b0; intdev = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      acc |= {ack1 | ack0 | ack3, |wstb1 | |wstb0, |rsel1, fl1};
      tick();
    end
    chk("nointdev", {28'b0, acc}, 0);
    // WAITS=3, reset during the wait aborts the cycle
    go(16'h0004, 1'b0);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_out", {wstb3[29:0], ack3, fl3}, 0);
    acc = '0;
    for (int i = 0; i < 5; i++) begin
      acc |= {ack3, |wstb3, |rsel3, fl3};
      tick();
    end
    chk("abort_noack", {28'b0, acc}, 0);
    go(16'h0004, 1'b0);
    tick(); tick();
    chk("w3_c3_ack", {31'b0, ack3}, 0);
    tick();
    chk("w3_c4_ack", {31'b0, ack3}, 1);
    chk("w3_c4_wstb", wstb3, 32'h4);
    idle(3);
    // back-to-back on u1: start in ACK ignored, next cycle accepted
    go(16'h0004, 1'b0);
    tick();
    chk("bb_ack1", {31'b0, ack1}, 1);
    a = 16'h0006; start = 1'b1;
    tick();
    chk("bb_ign_ack", {31'b0, ack1}, 0);
    chk("bb_ign_wstb", wstb1, 0);
    a = 16'h0008;
    tick();
    start = 1'b0;
    chk("bb_acc_ack", {31'b0, ack1}, 0);
    tick();
    chk("bb_acc_ack2", {31'b0, ack1}, 1);
    chk("bb_acc_wstb", wstb1, 32'h10);
    idle(4);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
